vreg_bank_ctrl: RTL and testbench
=================================

// Module: vreg_bank_ctrl
// PURPOSE
//  Parametrised scalar+vector register bank for the vector processor datapath.
//  Holds NSREG scalar and NVREG vector registers in on-chip flops, with one write port and two read ports.
//  Adds per-lane write masking, same-cycle write-to-read bypass, and a hardware clear sequencer.
//  Sits between decode (read addresses, rd_type) and writeback (write data, destination type).
// PARAMETERS
//  SW     21  scalar register width (bits)
//  LANES  8   vector lanes per vector register
//  LW     24  lane width (bits); vector width = LANES*LW
//  NSREG  8   number of scalar registers
//  NVREG  8   number of vector registers
//  AW     3   address width; must satisfy 2**AW >= max(NSREG,NVREG)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  clr_req    in   1         request full-bank clear (1-cycle pulse; sampled only when busy=0)
//  busy       out  1         clear sequence in progress; reads/writes ignored while high
//  wr_en      in   1         write enable
//  wr_dest    in   1         0 = scalar bank, 1 = vector bank
//  wa         in   AW        write address
//  wd_s       in   SW        scalar write data
//  wd_v       in   LANES*LW  vector write data; lane i = bits [i*LW +: LW]
//  wr_mask    in   LANES     vector lane write mask (1 = write lane); ignored for scalar writes
//  rd_en      in   1         read enable
//  rd_type    in   3         read-operand selector (see BEHAVIOUR)
//  ra1,ra2,ra3 in  AW each   read addresses
//  rd_valid   out  1         read results updated this cycle
//  r1e,r2e    out  SW each   scalar read results
//  r1v,r2v    out  LANES*LW  vector read results
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0, rd_valid=0, FSM -> CLEAR, clear index=0, busy=1.
//  FSM: CLEAR -> IDLE.
//   CLEAR: each cycle zero S[idx] (if idx<NSREG) and V[idx] (if idx<NVREG); idx++.
//     Exit to IDLE after idx = max(NSREG,NVREG)-1, so CLEAR lasts exactly max(NSREG,NVREG) cycles.
//   IDLE: busy=0; clr_req=1 -> CLEAR with idx=0 (busy goes high the next cycle).
//  rst asserted mid-CLEAR restarts idx at 0; outputs are re-zeroed.
//  wr_en/rd_en are ignored while busy=1: no state change, rd_valid=0.
//  Write (IDLE, wr_en=1), committed at posedge:
//   wr_dest=0: S[wa] <= wd_s.
//   wr_dest=1: for each lane i with wr_mask[i]=1, V[wa] lane i <= wd_v lane i; other lanes hold.
//   wr_mask = 0 makes the vector write a no-op.
//   wa >= NSREG (scalar) or wa >= NVREG (vector): write dropped silently.
//  Read (IDLE, rd_en=1): 1-cycle latency; outputs registered; rd_valid=1 the following cycle.
//   000: r2e<=S[ra1]       001: r1e<=S[ra1], r2v<=V[ra2]   010: no update
//   011: r1v<=V[ra1], r2v<=V[ra2]   100: r1e<=S[ra3]   101: r1e<=S[ra1], r2e<=S[ra2]
//   110/111: reserved, no update, rd_valid=0. Codes 000-101 pulse rd_valid (010 included).
//  Outputs not named by rd_type hold their previous value.
//  Out-of-range read address returns 0.
//  Bypass: a same-cycle write to the same bank+address returns the post-write value.
//   Vector bypass merges per lane: masked lanes from wd_v, unmasked lanes from stored V.
//  rd_valid is a 1-cycle pulse per accepted read; back-to-back reads give back-to-back pulses.
//  clr_req together with wr_en/rd_en in IDLE: the write and read complete this cycle, then CLEAR begins.
// TESTING
//  T1: rst 1 cycle -> busy=1 for exactly 8 cycles, then 0; all outputs 0; every register reads 0.
//  T2: write S[3]=21'h1ABCD; next cycle rd_type=000, ra1=3 -> next cycle r2e=21'h1ABCD, rd_valid=1.
//  T3: V[2]=all 24'hFFFFFF; write wd_v=0, wr_mask=8'b0000_0101; read 011 ra1=2
//      -> lanes 0,2 = 0, others = 24'hFFFFFF.
//  T4: same cycle: write S[5]=21'h00042 and read 101, ra1=5, ra2=0 -> r1e=21'h00042 (bypass), r2e=S[0].
//  T5: rst during CLEAR at idx=4 -> busy stays 1 for 8 more cycles; wr_en during busy leaves registers at 0.
//  T6: NSREG=6 build: write wa=7 then read 100 ra3=7 -> r1e=0; rd_type=111 -> rd_valid=0, outputs unchanged.

Source files
------------

// File: rtl/vreg_bank_ctrl.sv
// Scalar + vector register bank: one write port, two registered read ports,
// per-lane vector write masking, same-cycle write-to-read bypass and a clear sequencer.
module vreg_bank_ctrl #(
  parameter int SW    = 21,
  parameter int LANES = 8,
  parameter int LW    = 24,
  parameter int NSREG = 8,
  parameter int NVREG = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wr_en,
  input  logic                wr_dest,
  input  logic [AW-1:0]       wa,
  input  logic [SW-1:0]       wd_s,
  input  logic [LANES*LW-1:0] wd_v,
  input  logic [LANES-1:0]    wr_mask,
  input  logic                rd_en,
  input  logic [2:0]          rd_type,
  input  logic [AW-1:0]       ra1,
  input  logic [AW-1:0]       ra2,
  input  logic [AW-1:0]       ra3,
  output logic                rd_valid,
  output logic [SW-1:0]       r1e,
  output logic [SW-1:0]       r2e,
  output logic [LANES*LW-1:0] r1v,
  output logic [LANES*LW-1:0] r2v
);

  localparam int VW   = LANES * LW;
  localparam int MAXR = (NSREG > NVREG) ? NSREG : NVREG;
  localparam int CW   = (MAXR > 1) ? $clog2(MAXR) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   idx_reg, idx_next;

  logic [SW-1:0]   s_mem [NSREG];
  logic [VW-1:0]   v_mem [NVREG];

  logic            wr_ok;
  logic            rd_ok;
  logic [VW-1:0]   lane_bits;

  assign busy  = (state_reg == ST_CLEAR);
  assign wr_ok = wr_en && !busy;
  assign rd_ok = rd_en && !busy;

  // Expand the lane mask to a bit mask so vector writes and bypass share one merge.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_bits[gi*LW +: LW] = {LW{wr_mask[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (idx_reg == CW'(MAXR - 1)) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          idx_next   = '0;
        end
      end
    endcase
  end

  // Out-of-range write addresses never match a loop index, so they drop silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NSREG; i++) begin
        if (busy && idx_reg == CW'(i))
          s_mem[i] <= '0;
        else if (wr_ok && !wr_dest && wa == AW'(i))
          s_mem[i] <= wd_s;
      end
      for (int i = 0; i < NVREG; i++) begin
        if (busy && idx_reg == CW'(i))
          v_mem[i] <= '0;
        else if (wr_ok && wr_dest && wa == AW'(i))
          v_mem[i] <= (v_mem[i] & ~lane_bits) | (wd_v & lane_bits);
      end
    end
  end

  function automatic logic [SW-1:0] s_read(input logic [AW-1:0] a);
    logic [SW-1:0] val;
    val = '0;
    if (int'(a) < NSREG) begin
      val = s_mem[a];
      if (wr_ok && !wr_dest && wa == a)
        val = wd_s;
    end
    return val;
  endfunction

  function automatic logic [VW-1:0] v_read(input logic [AW-1:0] a);
    logic [VW-1:0] val;
    val = '0;
    if (int'(a) < NVREG) begin
      val = v_mem[a];
      if (wr_ok && wr_dest && wa == a)
        val = (val & ~lane_bits) | (wd_v & lane_bits);
    end
    return val;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      r1e      <= '0;
      r2e      <= '0;
      r1v      <= '0;
      r2v      <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_ok) begin
        case (rd_type)
          3'b000: r2e <= s_read(ra1);
          3'b001: begin
            r1e <= s_read(ra1);
            r2v <= v_read(ra2);
          end
          3'b011: begin
            r1v <= v_read(ra1);
            r2v <= v_read(ra2);
          end
          3'b100: r1e <= s_read(ra3);
          3'b101: begin
            r1e <= s_read(ra1);
            r2e <= s_read(ra2);
          end
          default: ;
        endcase
        rd_valid <= (rd_type <= 3'b101);
      end
    end
  end

endmodule

// File: tb/tb_vreg_bank_ctrl.sv
// Randomized + directed bench for vreg_bank_ctrl; two builds (NSREG=8 and NSREG=6)
// share one stimulus stream and are checked against a behavioural bank model.
module tb_vreg_bank_ctrl;

  localparam int SW = 21, LANES = 8, LW = 24, VW = 192, AW = 3, MAXR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clr_req, wr_en, wr_dest, rd_en;
  logic [AW-1:0]  wa, ra1, ra2, ra3;
  logic [2:0]     rd_type;
  logic [SW-1:0]  wd_s;
  logic [VW-1:0]  wd_v;
  logic [7:0]     wr_mask;

  logic           busy_w [2];
  logic           rd_valid_w [2];
  logic [SW-1:0]  r1e_w [2];
  logic [SW-1:0]  r2e_w [2];
  logic [VW-1:0]  r1v_w [2];
  logic [VW-1:0]  r2v_w [2];

  vreg_bank_ctrl #(.SW(SW), .LANES(LANES), .LW(LW), .NSREG(8), .NVREG(8), .AW(AW)) dut8 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_w[0]),
    .wr_en(wr_en), .wr_dest(wr_dest), .wa(wa), .wd_s(wd_s), .wd_v(wd_v), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_type(rd_type), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd_valid(rd_valid_w[0]), .r1e(r1e_w[0]), .r2e(r2e_w[0]), .r1v(r1v_w[0]), .r2v(r2v_w[0])
  );

  vreg_bank_ctrl #(.SW(SW), .LANES(LANES), .LW(LW), .NSREG(6), .NVREG(8), .AW(AW)) dut6 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_w[1]),
    .wr_en(wr_en), .wr_dest(wr_dest), .wa(wa), .wd_s(wd_s), .wd_v(wd_v), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_type(rd_type), .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd_valid(rd_valid_w[1]), .r1e(r1e_w[1]), .r2e(r2e_w[1]), .r1v(r1v_w[1]), .r2v(r2v_w[1])
  );

  // Behavioural model: index 0 = NSREG 8 build, index 1 = NSREG 6 build.
  int             ns [2] = '{8, 6};
  logic [SW-1:0]  ms [2][8];
  logic [VW-1:0]  mv [2][8];
  logic [SW-1:0]  x_r1e [2];
  logic [SW-1:0]  x_r2e [2];
  logic [VW-1:0]  x_r1v [2];
  logic [VW-1:0]  x_r2v [2];
  logic           x_valid [2];
  int             clear_left = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic logic [SW-1:0] m_s(input int k, input logic [AW-1:0] a);
    return (int'(a) < ns[k]) ? ms[k][a] : '0;
  endfunction

  task automatic zero_banks();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) begin
        ms[k][a] = '0;
        mv[k][a] = '0;
      end
  endtask

  task automatic model_update();
    if (rst) begin
      clear_left = MAXR;
      zero_banks();
      for (int k = 0; k < 2; k++) begin
        x_r1e[k] = '0; x_r2e[k] = '0; x_r1v[k] = '0; x_r2v[k] = '0; x_valid[k] = 1'b0;
      end
    end else if (clear_left > 0) begin
      clear_left--;
      for (int k = 0; k < 2; k++) x_valid[k] = 1'b0;
    end else begin
      if (wr_en || rd_en)
        $display("txn t=%0t wr=%0d dest=%0d wa=%0d mask=%h rd=%0d type=%0d ra=%0d/%0d/%0d clr=%0d",
                 $time, wr_en, wr_dest, wa, wr_mask, rd_en, rd_type, ra1, ra2, ra3, clr_req);
      for (int k = 0; k < 2; k++) begin
        // Reads see the bank after this cycle's write has landed.
        if (wr_en) begin
          if (!wr_dest) begin
            if (int'(wa) < ns[k]) ms[k][wa] = wd_s;
          end else begin
            for (int l = 0; l < LANES; l++)
              if (wr_mask[l]) mv[k][wa][l*LW +: LW] = wd_v[l*LW +: LW];
          end
        end
        x_valid[k] = 1'b0;
        if (rd_en) begin
          case (rd_type)
            3'd0: x_r2e[k] = m_s(k, ra1);
            3'd1: begin x_r1e[k] = m_s(k, ra1); x_r2v[k] = mv[k][ra2]; end
            3'd3: begin x_r1v[k] = mv[k][ra1]; x_r2v[k] = mv[k][ra2]; end
            3'd4: x_r1e[k] = m_s(k, ra3);
            3'd5: begin x_r1e[k] = m_s(k, ra1); x_r2e[k] = m_s(k, ra2); end
            default: ;
          endcase
          x_valid[k] = (rd_type < 3'd6);
        end
      end
      if (clr_req) begin
        clear_left = MAXR;
        zero_banks();
      end
    end
  endtask

  task automatic compare();
    string p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "n8" : "n6";
      check({p, ".busy"},     VW'(busy_w[k]),     VW'(clear_left > 0));
      check({p, ".rd_valid"}, VW'(rd_valid_w[k]), VW'(x_valid[k]));
      check({p, ".r1e"},      VW'(r1e_w[k]),      VW'(x_r1e[k]));
      check({p, ".r2e"},      VW'(r2e_w[k]),      VW'(x_r2e[k]));
      check({p, ".r1v"},      r1v_w[k],           x_r1v[k]);
      check({p, ".r2v"},      r2v_w[k],           x_r2v[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic quiet();
    rst = 1'b0; clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_type = 3'd5; ra1 = AW'(a); ra2 = AW'(7 - a);
      cycle();
      rd_type = 3'd3;
      cycle();
    end
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_dest = 1'b0; rd_en = 1'b0;
    wa = '0; ra1 = '0; ra2 = '0; ra3 = '0; rd_type = '0;
    wd_s = '0; wd_v = '0; wr_mask = '0;

    // T1: reset, exactly MAXR busy cycles, then every register reads zero
    cycle();
    quiet();
    repeat (MAXR) cycle();
    check("T1.busy_end", VW'(busy_w[0]), VW'(1'b0));
    read_all();

    // T2: scalar write then read via type 000
    wr_en = 1'b1; wr_dest = 1'b0; wa = 3'd3; wd_s = 21'h1ABCD;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_type = 3'd0; ra1 = 3'd3;
    cycle();
    rd_en = 1'b0;
    check("T2.r2e", VW'(r2e_w[0]), VW'(21'h1ABCD));
    check("T2.valid", VW'(rd_valid_w[0]), VW'(1'b1));

    // T3: masked vector write over all-ones register
    wr_en = 1'b1; wr_dest = 1'b1; wa = 3'd2; wd_v = {VW{1'b1}}; wr_mask = 8'hFF;
    cycle();
    wd_v = '0; wr_mask = 8'b0000_0101;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_type = 3'd3; ra1 = 3'd2; ra2 = 3'd2;
    cycle();
    rd_en = 1'b0;
    check("T3.r1v", r1v_w[0], {{5{24'hFFFFFF}}, 24'h0, 24'hFFFFFF, 24'h0});

    // T4: same-cycle write and read of S[5] (bypass), S[0] alongside
    wr_en = 1'b1; wr_dest = 1'b0; wa = 3'd5; wd_s = 21'h00042;
    rd_en = 1'b1; rd_type = 3'd5; ra1 = 3'd5; ra2 = 3'd0;
    cycle();
    quiet();
    check("T4.r1e_bypass", VW'(r1e_w[0]), VW'(21'h00042));
    check("T4.r2e", VW'(r2e_w[0]), VW'(21'h0));

    // Vector bypass with a partial mask
    wr_en = 1'b1; wr_dest = 1'b1; wa = 3'd2; wd_v = {8{24'h123456}}; wr_mask = 8'b1000_0010;
    rd_en = 1'b1; rd_type = 3'd1; ra1 = 3'd5; ra2 = 3'd2;
    cycle();
    quiet();
    check("T4.r2v_merge", r2v_w[0],
          {24'h123456, {4{24'hFFFFFF}}, 24'h0, 24'h123456, 24'h0});

    // T5: rst mid-clear restarts the sequence; writes during busy are ignored
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wr_en = 1'b1; wr_mask = 8'hFF; wd_s = 21'h1FFFFF; wd_v = {VW{1'b1}};
    for (int i = 0; i < MAXR; i++) begin
      wr_dest = i[0]; wa = AW'(i);
      cycle();
    end
    wr_en = 1'b0;
    check("T5.busy_end", VW'(busy_w[0]), VW'(1'b0));
    read_all();

    // T6: out-of-range scalar address on the NSREG=6 build; reserved read code
    wr_en = 1'b1; wr_dest = 1'b0; wa = 3'd7; wd_s = 21'h155555;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1; rd_type = 3'd4; ra3 = 3'd7;
    cycle();
    check("T6.oor_r1e", VW'(r1e_w[1]), VW'(21'h0));
    check("T6.inrange_r1e", VW'(r1e_w[0]), VW'(21'h155555));
    rd_type = 3'd7;
    cycle();
    rd_en = 1'b0;
    check("T6.reserved_valid", VW'(rd_valid_w[1]), VW'(1'b0));

    // clr_req together with a write and a read: both complete, then clear
    wr_en = 1'b1; wr_dest = 1'b0; wa = 3'd1; wd_s = 21'h0BEEF;
    rd_en = 1'b1; rd_type = 3'd5; ra1 = 3'd1; ra2 = 3'd7; clr_req = 1'b1;
    cycle();
    quiet();
    check("CLR.bypass_r1e", VW'(r1e_w[0]), VW'(21'h0BEEF));
    repeat (MAXR) cycle();
    read_all();

    // Randomized traffic
    for (int n = 0; n < 700; n++) begin
      rst     = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 59) == 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_dest = $urandom_range(0, 1) == 1;
      wa      = AW'($urandom_range(0, 7));
      wd_s    = SW'($urandom());
      for (int w = 0; w < 6; w++) wd_v[w*32 +: 32] = $urandom();
      wr_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
      rd_en   = $urandom_range(0, 3) != 0;
      rd_type = 3'($urandom_range(0, 7));
      ra1     = AW'($urandom_range(0, 7));
      ra2     = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
      ra3     = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ra1 = wa;
      cycle();
    end
    quiet();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
